alu_arbiter: RTL

- Shares the single combinational 32-bit ALU between two requesters: the CPU datapath (port 0) and the pixel/graphics engine (port 1).
- Arbitrates round-robin and holds the ALU operands registered for the op's latency. MUL is a multicycle path, so it is held for MUL_CYCLES.
- Captures the result and flags, then returns them to the granted requester with a one-cycle valid pulse.
- Sits between the requesters and the ALU instance in the system top.

---
 rtl/alu_arbiter_pkg.sv | 47 ++++
 rtl/alu_arbiter_alu.sv | 61 ++++++
 rtl/alu_arbiter_chk.sv | 39 +++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice: ALU opcode constants, requester
// identifiers, arbiter state encoding and the helper that turns an opcode into
// the hold-counter load value.
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

   // ALU opcodes (5-bit opCode field)
   localparam logic [4:0] ALUOp_ADD = 5'd0;
   localparam logic [4:0] ALUOp_SUB = 5'd1;
   localparam logic [4:0] ALUOp_AND = 5'd2;
   localparam logic [4:0] ALUOp_OR  = 5'd3;
   localparam logic [4:0] ALUOp_XOR = 5'd4;
   localparam logic [4:0] ALUOp_SLL = 5'd5;
   localparam logic [4:0] ALUOp_SRL = 5'd6;
   localparam logic [4:0] ALUOp_SRA = 5'd7;
   localparam logic [4:0] ALUOp_MUL = 5'd8;
   localparam logic [4:0] ALUOp_MOV = 5'd9;

   // Requester identifiers
   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_PIX = 1'b1
   } req_e;

   // Arbiter states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   // Counter load value: number of hold cycles minus one. MUL is a multicycle
   // path; everything else, including unknown opcodes, uses the short count.
   function automatic logic [3:0] op_count(input logic [4:0]  op,
                                           input int unsigned mul_cycles,
                                           input int unsigned alu_cycles);
      int unsigned n;
      if (op == ALUOp_MUL) begin
         n = mul_cycles;
      end else begin
         n = alu_cycles;
      end
      return 4'(n - 32'd1);
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Combinational 32-bit ALU shared by the CPU and the pixel engine. Sits beside
// alu_arbiter at system level; the arbiter holds its inputs stable.
//   opcode   in  5   operation select
//   src      in  32  rSrc operand (shift amount for shifts)
//   dst      in  32  rDst operand (value shifted for shifts)
//   result   out 32  operation result (0 for unknown opcodes)
//   psr_out  out 5   flags {N, Z, F(overflow), L(dst<src unsigned), C}
// -----------------------------------------------------------------------------
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [4:0]  opcode,
   input  logic [31:0] src,
   input  logic [31:0] dst,
   output logic [31:0] result,
   output logic [4:0]  psr_out
);

   logic [32:0] sum_s;
   logic [32:0] diff_s;
   logic [31:0] res_s;
   logic        c_s;
   logic        f_s;

   // Result and flag generation.
   always_comb begin
      sum_s  = {1'b0, dst} + {1'b0, src};
      diff_s = {1'b0, dst} - {1'b0, src};
      res_s  = 32'd0;
      c_s    = 1'b0;
      f_s    = 1'b0;
      case (opcode)
         ALUOp_ADD: begin
            res_s = sum_s[31:0];
            c_s   = sum_s[32];
            f_s   = (dst[31] == src[31]) && (sum_s[31] != dst[31]);
         end
         ALUOp_SUB: begin
            // bit 32 of the zero-extended difference is the borrow
            res_s = diff_s[31:0];
            c_s   = diff_s[32];
            f_s   = (dst[31] != src[31]) && (diff_s[31] != dst[31]);
         end
         ALUOp_AND: res_s = dst & src;
         ALUOp_OR:  res_s = dst | src;
         ALUOp_XOR: res_s = dst ^ src;
         ALUOp_SLL: res_s = dst << src[4:0];
         ALUOp_SRL: res_s = dst >> src[4:0];
         ALUOp_SRA: res_s = $unsigned($signed(dst) >>> src[4:0]);
         ALUOp_MUL: res_s = dst * src;
         ALUOp_MOV: res_s = src;
         default:   res_s = 32'd0;
      endcase
   end

   assign result  = res_s;
   assign psr_out = {res_s[31], (res_s == 32'd0), f_s, (dst < src), c_s};

endmodule

// File: rtl/alu_arbiter_chk.sv
// -----------------------------------------------------------------------------
// alu_arbiter_chk
// Simulation-time checker placed beside alu_arbiter: rejects out-of-range
// cycle parameters and flags handshake exclusivity violations.
//   clk, reset                     clock, synchronous active-high reset
//   cpu/pix_req_ready, rsp_valid   observed arbiter outputs
//   busy                           observed busy flag
// -----------------------------------------------------------------------------
module alu_arbiter_chk #(
   parameter int MUL_CYCLES = 3,
   parameter int ALU_CYCLES = 1
)
(
   input logic clk,
   input logic reset,
   input logic cpu_req_ready,
   input logic pix_req_ready,
   input logic cpu_rsp_valid,
   input logic pix_rsp_valid,
   input logic busy
);

   // Parameter legality and one-hot handshake checks, sampled each cycle.
   always @(posedge clk) begin
      if (!reset) begin
         assert ((MUL_CYCLES >= 1) && (MUL_CYCLES <= 15))
            else $error("alu_arbiter_chk: MUL_CYCLES %0d outside 1..15", MUL_CYCLES);
         assert ((ALU_CYCLES >= 1) && (ALU_CYCLES <= 15))
            else $error("alu_arbiter_chk: ALU_CYCLES %0d outside 1..15", ALU_CYCLES);
         assert (!(cpu_req_ready && pix_req_ready))
            else $error("alu_arbiter_chk: both readies high");
         assert (!(cpu_rsp_valid && pix_rsp_valid))
            else $error("alu_arbiter_chk: both responses high");
         assert (!(busy && (cpu_req_ready || pix_req_ready)))
            else $error("alu_arbiter_chk: ready while busy");
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter sharing one combinational ALU between the CPU datapath
// (port 0) and the pixel engine (port 1). One request is accepted in IDLE; its
// operands are then held on the alu_* outputs for the op's latency, the result
// (and, for the CPU, the flags) is captured, and a one-cycle rsp_valid pulse is
// returned to the owner.
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req_valid/ready, cpu_op/src/dst   CPU request handshake and operands
//   cpu_rsp_valid, cpu_result, cpu_psr    CPU response pulse, result, flags
//   pix_req_valid/ready, pix_op/src/dst   pixel request handshake and operands
//   pix_rsp_valid, pix_result             pixel response pulse, result
//   alu_op/src/dst, alu_result/psr        shared ALU interface
//   busy                                  high while an op is in flight
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int MUL_CYCLES = 3,
   parameter int ALU_CYCLES = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   input  logic [4:0]  cpu_op,
   input  logic [31:0] cpu_src,
   input  logic [31:0] cpu_dst,
   output logic        cpu_rsp_valid,
   output logic [31:0] cpu_result,
   output logic [4:0]  cpu_psr,
   input  logic        pix_req_valid,
   output logic        pix_req_ready,
   input  logic [4:0]  pix_op,
   input  logic [31:0] pix_src,
   input  logic [31:0] pix_dst,
   output logic        pix_rsp_valid,
   output logic [31:0] pix_result,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_src,
   output logic [31:0] alu_dst,
   input  logic [31:0] alu_result,
   input  logic [4:0]  alu_psr,
   output logic        busy
);

   localparam int unsigned MUL_N = MUL_CYCLES;
   localparam int unsigned ALU_N = ALU_CYCLES;

   state_e      state_r;
   logic [3:0]  count_r;
   req_e        owner_r;
   req_e        last_grant_r;
   logic        grant_cpu_s;
   logic        grant_pix_s;

   // Round-robin grant; only meaningful in IDLE, and a tie goes to whichever
   // port did not win last time.
   always_comb begin
      grant_cpu_s = 1'b0;
      grant_pix_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (cpu_req_valid && pix_req_valid) begin
            if (last_grant_r == REQ_PIX) begin
               grant_cpu_s = 1'b1;
            end else begin
               grant_pix_s = 1'b1;
            end
         end else if (cpu_req_valid) begin
            grant_cpu_s = 1'b1;
         end else if (pix_req_valid) begin
            grant_pix_s = 1'b1;
         end else begin
            grant_cpu_s = 1'b0;
         end
      end else begin
         grant_cpu_s = 1'b0;
      end
   end

   assign cpu_req_ready = grant_cpu_s;
   assign pix_req_ready = grant_pix_s;
   assign busy          = (state_r != ST_IDLE);

   // Arbiter FSM: accept, hold operands while the counter runs, capture and
   // pulse the owner's response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         count_r       <= 4'd0;
         owner_r       <= REQ_CPU;
         last_grant_r  <= REQ_PIX;
         alu_op        <= 5'd0;
         alu_src       <= 32'd0;
         alu_dst       <= 32'd0;
         cpu_result    <= 32'd0;
         cpu_psr       <= 5'd0;
         pix_result    <= 32'd0;
         cpu_rsp_valid <= 1'b0;
         pix_rsp_valid <= 1'b0;
      end else begin
         cpu_rsp_valid <= 1'b0;
         pix_rsp_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_cpu_s) begin
                  alu_op       <= cpu_op;
                  alu_src      <= cpu_src;
                  alu_dst      <= cpu_dst;
                  owner_r      <= REQ_CPU;
                  last_grant_r <= REQ_CPU;
                  count_r      <= op_count(cpu_op, MUL_N, ALU_N);
                  state_r      <= ST_EXEC;
               end else if (grant_pix_s) begin
                  alu_op       <= pix_op;
                  alu_src      <= pix_src;
                  alu_dst      <= pix_dst;
                  owner_r      <= REQ_PIX;
                  last_grant_r <= REQ_PIX;
                  count_r      <= op_count(pix_op, MUL_N, ALU_N);
                  state_r      <= ST_EXEC;
               end else begin
                  // alu_* deliberately hold their last values
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               if (count_r != 4'd0) begin
                  count_r <= count_r - 4'd1;
               end else begin
                  if (owner_r == REQ_CPU) begin
                     cpu_result    <= alu_result;
                     cpu_psr       <= alu_psr;
                     cpu_rsp_valid <= 1'b1;
                  end else begin
                     pix_result    <= alu_result;
                     pix_rsp_valid <= 1'b1;
                  end
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               count_r <= 4'd0;
            end
         endcase
      end
   end

endmodule
